// File: rtl/march_scheduler.sv
// Sphere-tracing ray scheduler: keeps rays marching through a fixed-latency SDF pipeline and queues finished rays.
// Optional MARCH_STATS_EN adds retired-ray and issue counters.
module march_scheduler #(
  parameter int          SDF_LATENCY = 8,
  parameter int          MAX_STEPS   = 64,
  parameter logic [26:0] HIT_THRESH  = 27'h1F00000,
  parameter int          RES_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  output logic        sdf_valid,
  output logic [9:0]  sdf_x,
  output logic [9:0]  sdf_y,
  output logic [7:0]  sdf_step,
  input  logic [26:0] sdf_distance,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [9:0]  res_x,
  output logic [9:0]  res_y,
  output logic [7:0]  res_steps,
  output logic        res_hit
`ifdef MARCH_STATS_EN
  ,
  output logic [31:0] stat_rays,
  output logic [31:0] stat_steps
`endif
);

  localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic [SDF_LATENCY-1:0] dl_valid;
  logic [9:0]             dl_x    [SDF_LATENCY];
  logic [9:0]             dl_y    [SDF_LATENCY];
  logic [7:0]             dl_step [SDF_LATENCY];

  logic [28:0]  fifo_mem [RES_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic       ret_valid, hit, last, retire, full, push, pop, recirc, accept;
  logic [9:0] ret_x, ret_y;
  logic [7:0] ret_step;

  assign ret_valid = dl_valid[SDF_LATENCY-1] && !reset;
  assign ret_x     = dl_x[SDF_LATENCY-1];
  assign ret_y     = dl_y[SDF_LATENCY-1];
  assign ret_step  = dl_step[SDF_LATENCY-1];

  assign hit    = sdf_distance[26] || (sdf_distance[25:0] < HIT_THRESH[25:0]);
  assign last   = (ret_step == 8'(MAX_STEPS - 1));
  assign retire = ret_valid && (hit || last);
  // A pop in the same cycle does not make room: a full FIFO always bounces.
  assign full   = (count == (AW+1)'(RES_DEPTH));
  assign push   = retire && !full;
  assign recirc = ret_valid && !push;

  assign req_ready = !reset && !recirc;
  assign accept    = req_valid && req_ready;
  assign sdf_valid = recirc || accept;

  always_comb begin
    sdf_x    = req_x;
    sdf_y    = req_y;
    sdf_step = 8'd0;
    if (recirc) begin
      sdf_x    = ret_x;
      sdf_y    = ret_y;
      sdf_step = retire ? ret_step : ret_step + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_valid <= '0;
    end else begin
      for (int i = SDF_LATENCY - 1; i > 0; i--) dl_valid[i] <= dl_valid[i-1];
      dl_valid[0] <= sdf_valid;
    end
    for (int i = SDF_LATENCY - 1; i > 0; i--) begin
      dl_x[i]    <= dl_x[i-1];
      dl_y[i]    <= dl_y[i-1];
      dl_step[i] <= dl_step[i-1];
    end
    dl_x[0]    <= sdf_x;
    dl_y[0]    <= sdf_y;
    dl_step[0] <= sdf_step;
  end

  assign res_valid = !reset && (count != '0);
  assign pop       = res_valid && res_ready;
  assign {res_x, res_y, res_steps, res_hit} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {ret_x, ret_y, ret_step + 8'd1, hit};
        wr_ptr <= (wr_ptr == AW'(RES_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(RES_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MARCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rays  <= '0;
      stat_steps <= '0;
    end else begin
      if (push)      stat_rays  <= stat_rays + 32'd1;
      if (sdf_valid) stat_steps <= stat_steps + 32'd1;
    end
  end
`endif

endmodule

// File: doc/march_scheduler.md
MARCH_SCHEDULER -- requirements
Module: march_scheduler

Interface
REQ-001 SHALL have parameter SDF_LATENCY, default 8, meaning fixed cycles from sdf issue to sdf_distance valid (range 1..32).
REQ-002 SHALL have parameter MAX_STEPS, default 64, meaning march iterations per ray before forced miss retirement (range 1..255).
REQ-003 SHALL have parameter HIT_THRESH, default 27'h1F00000, meaning the 27-bit float surface-hit threshold (sign bit 0).
REQ-004 SHALL have parameter RES_DEPTH, default 4, meaning result FIFO entries (power of 2).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port reset, input, 1, meaning the reset, which is synchronous and active-high.
REQ-007 SHALL have ports req_valid/req_ready, input/output, 1 each, meaning new-pixel handshake.
REQ-008 SHALL have ports req_x/req_y, input, 10 each, meaning pixel coordinates of a new ray.
REQ-009 SHALL have port sdf_valid, output, 1, meaning sample issued to the sdf pipeline this cycle.
REQ-010 SHALL have ports sdf_x/sdf_y, output, 10 each, plus sdf_step, output, 8, meaning pixel and iteration of the issued sample.
REQ-011 SHALL have port sdf_distance, input, 27, meaning sdf result, sampled exactly SDF_LATENCY cycles after the matching issue.
REQ-012 SHALL have ports res_valid/res_ready, output/input, 1 each, meaning result handshake.
REQ-013 SHALL have ports res_x/res_y, output, 10 each; res_steps, output, 8; res_hit, output, 1.

Function
REQ-014 SHALL hold a metadata delay line of SDF_LATENCY stages (valid, x, y, step) aligned with the sdf pipeline; stage SDF_LATENCY-1 is the "return" slot.
REQ-015 SHALL classify a valid return as hit when sdf_distance[26]=1 or sdf_distance[25:0] < HIT_THRESH[25:0] (unsigned compare).
REQ-016 SHALL retire a return when hit, or when step == MAX_STEPS-1 (res_hit=0), by pushing {x,y,step+1,hit} into the result FIFO.
REQ-017 SHALL recirculate a non-retiring return by issuing it same cycle with step+1.
REQ-018 SHALL, when a retiring return finds the result FIFO full, recirculate it with step unchanged (bounce); no result is ever dropped.
REQ-019 SHALL give recirculation strict priority over new requests; req_ready = !reset && !(return valid && recirculating this cycle).
REQ-020 SHALL issue a new ray with step 0 when req_valid && req_ready; a retiring return frees its slot for a new request the same cycle.
REQ-021 SHALL assert sdf_valid only on recirculation or accepted request; at most one issue per cycle.
REQ-022 SHALL present FIFO head on res_*; pop on res_valid && res_ready; simultaneous push and pop on full FIFO SHALL count as full (bounce).
REQ-023 SHALL hold res_* stable while res_valid && !res_ready.
REQ-024 SHALL have issue latency of 0 cycles (combinational from req to sdf_*) and retire-to-res_valid latency of 1 cycle when FIFO was empty.

Reset
REQ-025 SHALL, on reset, clear all delay-line valid bits, FIFO pointers, and counters; res_valid=0, sdf_valid=0, req_ready=0 while reset is high.
REQ-026 SHALL discard in-flight rays on mid-operation reset; sdf_distance returning after reset SHALL be ignored.

Configuration
REQ-027 SHALL, with MARCH_STATS_EN defined, add outputs stat_rays (32) and stat_steps (32), counting retired rays and total issues (wrapping), cleared on reset.
REQ-028 SHALL, without MARCH_STATS_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-029 SHALL cover: single req (x=5,y=7), sdf_distance=0 on return -> res after SDF_LATENCY+1 cycles, res_hit=1, res_steps=1.
REQ-030 SHALL cover: single req, sdf_distance=27'h3FFFFFF always, MAX_STEPS=4 -> exactly 4 issues, steps 0..3, res_hit=0, res_steps=4.
REQ-031 SHALL cover: req_valid held high continuously with returns never hitting -> req_ready low on every recirculation cycle; no sdf_valid collisions.
REQ-032 SHALL cover: res_ready=0, 5 hitting rays, RES_DEPTH=4 -> 4 queued, 5th bounces with step unchanged until res_ready=1, then 5 results in issue order.
REQ-033 SHALL cover: reset pulsed with 3 rays in flight -> no res_valid afterwards, req_ready=1 the cycle after reset deasserts.
REQ-034 SHALL cover (MARCH_STATS_EN): scenario REQ-030 -> stat_rays=1, stat_steps=4.
